multi_pulse_gen: RTL and testbench
==================================

MULTI_PULSE_GEN -- requirements
Module: multi_pulse_gen

Interface
REQ-001 Parameter N_CH, default 4, number of independent pulse channels (1..16).
REQ-002 Parameter DIV_W, default 24, width of each channel divisor and counter.
REQ-003 Parameter DIV_RESET, default 12000, divisor loaded into every channel on reset (1 kHz at 12 MHz).
REQ-004 Parameter CH_W, default 4, width of channel index; SHALL satisfy 2**CH_W >= N_CH.
REQ-005 i_clk  in  1  system clock, 12 MHz nominal; all logic on rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_enable  in  N_CH  per-channel run enable; level-sensitive.
REQ-008 i_mode  in  N_CH  per-channel mode: 0 periodic, 1 one-shot.
REQ-009 i_trigger  in  N_CH  per-channel one-shot start strobe; ignored in periodic mode.
REQ-010 i_load  in  1  divisor write strobe, one cycle.
REQ-011 i_load_ch  in  CH_W  channel index for i_load.
REQ-012 i_load_div  in  DIV_W  divisor value for i_load.
REQ-013 i_sync  in  1  strobe: restart all channel counters in phase.
REQ-014 o_pulse  out  N_CH  registered one-cycle pulse per channel.
REQ-015 o_active  out  N_CH  channel counting (periodic enabled, or one-shot in flight).
REQ-016 o_load_err  out  1  one-cycle flag: i_load with i_load_ch >= N_CH.

Function
REQ-017 Each channel SHALL hold a shadow divisor S, an active divisor D and a counter C (DIV_W bits each).
REQ-018 Effective divisor SHALL be max(D,1); D=0 behaves as D=1.
REQ-019 Periodic, enabled: each edge, if C == Deff-1 then C<=0, o_pulse<=1, else C<=C+1, o_pulse<=0.
REQ-020 Periodic: first pulse SHALL assert on the edge completing the Deff-th consecutive enabled cycle; period thereafter exactly Deff cycles; Deff=1 gives o_pulse high every cycle.
REQ-021 i_enable low: C<=0, o_pulse<=0, o_active<=0 on next edge; re-enable restarts from C=0.
REQ-022 i_load with valid index SHALL write S of that channel only; other channels unaffected.
REQ-023 D SHALL copy S at each counter wrap (C returning to 0), when channel is idle/disabled, and on i_sync; no mid-period change, no truncated or stretched period.
REQ-024 i_load with i_load_ch >= N_CH SHALL change no state and raise o_load_err for one cycle.
REQ-025 i_sync: all channels C<=0, D<=S, o_pulse<=0 that edge; shadow written by a same-cycle i_load SHALL be the value copied.
REQ-026 One-shot, enabled: idle until i_trigger; trigger sets o_active and starts C from 0; o_pulse asserts once after Deff cycles, then o_active<=0 same edge.
REQ-027 One-shot retrigger while o_active SHALL be ignored; trigger on the same edge active clears SHALL start a new shot.
REQ-028 Mode change while active SHALL abort the channel: C<=0, o_active<=0, no pulse.
REQ-029 Trigger with i_enable low SHALL be ignored.
REQ-030 i_sync SHALL abort in-flight one-shots (o_active<=0).

Reset
REQ-031 i_reset high at an edge: S<=DIV_RESET, D<=DIV_RESET, C<=0 for all channels.
REQ-032 Reset values: o_pulse=0, o_active=0, o_load_err=0.
REQ-033 Reset SHALL override i_load, i_sync and i_trigger on the same edge; mid-period reset discards the partial period.

Verification
REQ-034 Reset, ch0 periodic, load D=5, enable -> o_pulse[0] first high 5 cycles after enable, then every 5 cycles.
REQ-035 Ch1 D=4 running; load 7 mid-period -> current period stays 4, subsequent periods 7.
REQ-036 Ch2 one-shot D=3, trigger, retrigger 1 cycle later -> exactly one pulse 3 cycles after first trigger; o_active high 3 cycles.
REQ-037 Ch0 D=3, ch1 D=6 running, i_sync -> both restart; coincident pulses every 6 cycles.
REQ-038 i_load_ch=5 with N_CH=4 -> o_load_err one cycle, all S unchanged; load D=0 -> pulse every cycle.
REQ-039 i_reset for 1 cycle mid-period -> outputs 0, next period DIV_RESET cycles.

Source files
------------

// File: rtl/multi_pulse_gen.sv
// Multi-channel programmable pulse generator: periodic or one-shot per channel,
// with shadowed divisors that only take effect at period boundaries.
module multi_pulse_gen #(
    parameter int N_CH      = 4,
    parameter int DIV_W     = 24,
    parameter int DIV_RESET = 12000,
    parameter int CH_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_CH-1:0]   i_enable,
    input  logic [N_CH-1:0]   i_mode,
    input  logic [N_CH-1:0]   i_trigger,
    input  logic              i_load,
    input  logic [CH_W-1:0]   i_load_ch,
    input  logic [DIV_W-1:0]  i_load_div,
    input  logic              i_sync,
    output logic [N_CH-1:0]   o_pulse,
    output logic [N_CH-1:0]   o_active,
    output logic              o_load_err
);

    localparam logic [CH_W:0]  ERR_LIM = (CH_W+1)'(N_CH);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RESET);

    logic [DIV_W-1:0] s_q [N_CH];
    logic [DIV_W-1:0] s_d [N_CH];
    logic [DIV_W-1:0] d_q [N_CH];
    logic [DIV_W-1:0] d_d [N_CH];
    logic [DIV_W-1:0] c_q [N_CH];
    logic [DIV_W-1:0] c_d [N_CH];
    logic [N_CH-1:0]  pulse_q, pulse_d;
    logic [N_CH-1:0]  active_q, active_d;
    logic [N_CH-1:0]  mode_q;
    logic [N_CH-1:0]  wrap;
    logic [N_CH-1:0]  idle;
    logic             err_q, err_d;

    always_comb begin
        err_d    = i_load && ({1'b0, i_load_ch} >= ERR_LIM);
        pulse_d  = '0;
        active_d = active_q;
        wrap     = '0;
        idle     = '0;
        for (int c = 0; c < N_CH; c++) begin
            s_d[c] = s_q[c];
            d_d[c] = d_q[c];
            c_d[c] = c_q[c];
            if (i_load && (i_load_ch == CH_W'(c))) begin
                s_d[c] = i_load_div;
            end
            // A zero divisor behaves as one: wrap on every cycle
            wrap[c] = (d_q[c] == '0) ? (c_q[c] == '0)
                                     : (c_q[c] == d_q[c] - DIV_W'(1));
            idle[c] = i_sync || !i_enable[c] ||
                      (active_q[c] && (i_mode[c] != mode_q[c]));
            if (idle[c]) begin
                c_d[c]      = '0;
                d_d[c]      = s_d[c];
                active_d[c] = 1'b0;
            end else if (!i_mode[c]) begin
                active_d[c] = 1'b1;
                if (wrap[c]) begin
                    c_d[c]     = '0;
                    d_d[c]     = s_d[c];
                    pulse_d[c] = 1'b1;
                end else begin
                    c_d[c] = c_q[c] + DIV_W'(1);
                end
            end else if (active_q[c]) begin
                if (wrap[c]) begin
                    c_d[c]      = '0;
                    d_d[c]      = s_d[c];
                    pulse_d[c]  = 1'b1;
                    active_d[c] = i_trigger[c];
                end else begin
                    c_d[c] = c_q[c] + DIV_W'(1);
                end
            end else begin
                c_d[c]      = '0;
                d_d[c]      = s_d[c];
                active_d[c] = i_trigger[c];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        mode_q <= i_mode;
        if (i_reset) begin
            for (int c = 0; c < N_CH; c++) begin
                s_q[c] <= DIV_RST;
                d_q[c] <= DIV_RST;
                c_q[c] <= '0;
            end
            pulse_q  <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                s_q[c] <= s_d[c];
                d_q[c] <= d_d[c];
                c_q[c] <= c_d[c];
            end
            pulse_q  <= pulse_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    assign o_pulse    = pulse_q;
    assign o_active   = active_q;
    assign o_load_err = err_q;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed scenarios plus random traffic for multi_pulse_gen, checked
// cycle by cycle against an elapsed-time reference model.
module tb_multi_pulse_gen;

    localparam int N  = 4;
    localparam int DW = 24;
    localparam int DR = 12000;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, load, sync;
    logic [N-1:0]  en, mode, trig;
    logic [CW-1:0] lch;
    logic [DW-1:0] ldiv;
    logic [N-1:0]  pulse, active;
    logic          err;

    int total = 0;
    int bad   = 0;

    int sh  [N];
    int per [N];
    int el  [N];
    bit act [N];
    bit pul [N];
    bit pm  [N];
    bit merr;

    always #5 clk = ~clk;

    multi_pulse_gen #(.N_CH(N), .DIV_W(DW), .DIV_RESET(DR), .CH_W(CW)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_enable   (en),
        .i_mode     (mode),
        .i_trigger  (trig),
        .i_load     (load),
        .i_load_ch  (lch),
        .i_load_div (ldiv),
        .i_sync     (sync),
        .o_pulse    (pulse),
        .o_active   (active),
        .o_load_err (err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each channel tracks cycles elapsed in the current period against
    // the divisor latched at the period start.
    task automatic model();
        int eff;
        if (reset) begin
            merr = 1'b0;
            for (int c = 0; c < N; c++) begin
                sh[c] = DR; per[c] = DR; el[c] = 0;
                act[c] = 1'b0; pul[c] = 1'b0; pm[c] = mode[c];
            end
            return;
        end
        merr = load && (int'(lch) >= N);
        if (load && int'(lch) < N) sh[int'(lch)] = int'(ldiv);
        for (int c = 0; c < N; c++) begin
            eff = (per[c] == 0) ? 1 : per[c];
            pul[c] = 1'b0;
            if (sync || !en[c] || (act[c] && (mode[c] != pm[c]))) begin
                el[c] = 0; act[c] = 1'b0; per[c] = sh[c];
            end else if (!mode[c]) begin
                act[c] = 1'b1;
                el[c]++;
                if (el[c] == eff) begin
                    pul[c] = 1'b1; el[c] = 0; per[c] = sh[c];
                end
            end else if (act[c]) begin
                el[c]++;
                if (el[c] == eff) begin
                    pul[c] = 1'b1; el[c] = 0; per[c] = sh[c];
                    act[c] = trig[c];
                end
            end else begin
                per[c] = sh[c]; el[c] = 0; act[c] = trig[c];
            end
            pm[c] = mode[c];
        end
    endtask

    task automatic cyc();
        logic [N-1:0] ep, ea;
        @(posedge clk);
        model();
        #1;
        for (int c = 0; c < N; c++) begin
            ep[c] = pul[c];
            ea[c] = act[c];
        end
        chk("pulse", int'(pulse), int'(ep));
        chk("active", int'(active), int'(ea));
        chk("load_err", int'(err), int'(merr));
        reset = 1'b0; load = 1'b0; sync = 1'b0; trig = '0;
    endtask

    task automatic do_load(input int ch, input int div);
        load = 1'b1;
        lch  = CW'(ch);
        ldiv = DW'(div);
        cyc();
    endtask

    initial begin
        int first, np, na, ppos, nco;
        reset = 1'b1; load = 1'b0; sync = 1'b0;
        en = '0; mode = '0; trig = '0; lch = '0; ldiv = '0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("rst_pulse", int'(pulse), 0);
        chk("rst_active", int'(active), 0);

        // ch0 periodic, divisor 5
        do_load(0, 5);
        en[0] = 1'b1;
        first = 0; np = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (pulse[0]) begin
                np++;
                if (first == 0) first = i;
            end
        end
        chk("p5_first", first, 5);
        chk("p5_count", np, 3);

        // ch1 divisor 4, change to 7 mid-period
        do_load(1, 4);
        en[1] = 1'b1;
        cyc(); cyc();
        do_load(1, 7);
        for (int i = 0; i < 24; i++) cyc();

        // ch2 one-shot with retrigger
        mode[2] = 1'b1;
        do_load(2, 3);
        en[2] = 1'b1;
        cyc(); cyc();
        np = 0; na = 0; ppos = -1;
        for (int i = 0; i < 8; i++) begin
            if (i < 2) trig[2] = 1'b1;
            cyc();
            if (pulse[2]) begin np++; ppos = i; end
            if (active[2]) na++;
        end
        chk("os_pulses", np, 1);
        chk("os_pos", ppos, 3);
        chk("os_active", na, 3);

        // sync with same-cycle load
        do_load(0, 3);
        load = 1'b1; lch = 1; ldiv = 6; sync = 1'b1;
        cyc();
        nco = 0;
        for (int i = 1; i <= 18; i++) begin
            cyc();
            if (pulse[0] && pulse[1]) nco++;
        end
        chk("sync_coinc", nco, 3);

        // invalid channel, then divisor zero
        do_load(5, 9);
        chk("bad_ch_err", int'(err), 1);
        cyc();
        chk("err_clear", int'(err), 0);
        do_load(3, 0);
        en[3] = 1'b1;
        np = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (pulse[3]) np++;
        end
        chk("div0_count", np, 6);

        // mid-period reset overriding other strobes
        reset = 1'b1; load = 1'b1; lch = 0; ldiv = 2; sync = 1'b1; trig = '1;
        cyc();
        chk("rst2_pulse", int'(pulse), 0);
        chk("rst2_active", int'(active), 0);
        first = 0;
        for (int i = 1; i <= 12005; i++) begin
            cyc();
            if (pulse[0] && first == 0) first = i;
        end
        chk("rst_period", first, DR);

        // random traffic
        for (int c = 0; c < N; c++) do_load(c, $urandom_range(0, 6));
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 24) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 29) == 0) mode[c] = ~mode[c];
                trig[c] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 4) == 0) begin
                load = 1'b1;
                lch  = CW'($urandom_range(0, 5));
                ldiv = DW'($urandom_range(0, 7));
            end
            sync  = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
